alu: RTL and testbench



---
 rtl/alu_pkg.sv | 15 +
 rtl/alu_shifter.sv | 37 +++
 rtl/alu.sv | 75 +++++++
 tb/tb_alu.sv | 111 +++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared RV32I ALU decode constants: funct3 operation selects and the funct7 alternate-op bit.
package alu_pkg;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam int unsigned F7_ALT_BIT = 5;

endpackage

// File: rtl/alu_shifter.sv
// Logarithmic barrel shifter for SLL/SRL/SRA.
// Each amount bit enables one power-of-two stage.
module alu_shifter #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic [XLEN-1:0]    a_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  input  logic               dir_i,    // 0: left, 1: right
  input  logic               arith_i,  // right shifts only: fill with sign bit
  output logic [XLEN-1:0]    out_o
);

  logic [XLEN-1:0] ones;
  logic            fill;
  logic [XLEN-1:0] stage;

  assign ones = '1;
  assign fill = dir_i & arith_i & a_i[XLEN-1];

  always_comb begin
    stage = a_i;
    for (int unsigned i = 0; i < SHAMT_W; i++) begin
      if (shamt_i[i]) begin
        if (dir_i) begin
          // Zero-filled right shift, then OR in the vacated high bits for sign fill.
          stage = (stage >> (1 << i)) | (fill ? ~(ones >> (1 << i)) : '0);
        end else begin
          stage = stage << (1 << i);
        end
      end
    end
  end

  assign out_o = stage;

endmodule

// File: rtl/alu.sv
// RV32I integer ALU: decodes funct3/funct7 directly into one combinational 32-bit result.
// clk and rst exist only for datapath interface uniformity and do not affect Result.
module alu
  import alu_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  output logic [XLEN-1:0] Result,
  input  logic            clk,
  input  logic            rst
);

  logic            alt;
  logic [XLEN-1:0] b_op;
  logic [XLEN-1:0] add_res;
  logic            lt_s;
  logic            lt_u;
  logic [XLEN-1:0] sll_res;
  logic [XLEN-1:0] sr_res;

  assign alt = funct7[F7_ALT_BIT];

  // Subtract as A + ~B + 1 so one adder serves both ADD and SUB.
  assign b_op    = (alt && funct3 == F3_ADD) ? ~B : B;
  assign add_res = A + b_op + {{(XLEN-1){1'b0}}, (alt && funct3 == F3_ADD)};

  assign lt_s = $signed(A) < $signed(B);
  assign lt_u = A < B;

  alu_shifter #(
    .XLEN    (XLEN),
    .SHAMT_W (SHAMT_W)
  ) u_sll (
    .a_i     (A),
    .shamt_i (B[SHAMT_W-1:0]),
    .dir_i   (1'b0),
    .arith_i (1'b0),
    .out_o   (sll_res)
  );

  alu_shifter #(
    .XLEN    (XLEN),
    .SHAMT_W (SHAMT_W)
  ) u_sr (
    .a_i     (A),
    .shamt_i (B[SHAMT_W-1:0]),
    .dir_i   (1'b1),
    .arith_i (alt),
    .out_o   (sr_res)
  );

  always_comb begin
    Result = '0;
    case (funct3)
      F3_ADD:  Result = add_res;
      F3_SLL:  Result = sll_res;
      F3_SLT:  Result = {{(XLEN-1){1'b0}}, lt_s};
      F3_SLTU: Result = {{(XLEN-1){1'b0}}, lt_u};
      F3_XOR:  Result = A ^ B;
      F3_SR:   Result = sr_res;
      F3_OR:   Result = A | B;
      F3_AND:  Result = A & B;
      default: Result = '0;
    endcase
  end

  logic unused_inputs;
  assign unused_inputs = ^{clk, rst, funct7[6], funct7[4:0], B[XLEN-1:SHAMT_W]};

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for the RV32I ALU, including clockless and reset-insensitivity checks.
module tb_alu;

  logic [31:0] A;
  logic [31:0] B;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] Result;
  logic        clk;
  logic        rst;
  logic        clk_run;

  int unsigned n_tests;
  int unsigned n_fail;

  alu #(
    .XLEN    (32),
    .SHAMT_W (5)
  ) dut (
    .A      (A),
    .B      (B),
    .funct3 (funct3),
    .funct7 (funct7),
    .Result (Result),
    .clk    (clk),
    .rst    (rst)
  );

  initial clk = 1'b0;
  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic run_vec(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] exp);
    A = a; B = b; funct3 = f3; funct7 = f7;
    #10;
    check(tag, Result, exp);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    clk_run = 1'b1;
    rst     = 1'b1;
    A = '0; B = '0; funct3 = '0; funct7 = '0;
    #2;
    check("reset_zero_add", Result, 32'h0000_0000);
    rst = 1'b0;

    run_vec("add",        32'd5,         32'd3,         3'b000, 7'h00, 32'd8);
    run_vec("sub",        32'd5,         32'd3,         3'b000, 7'h20, 32'd2);
    run_vec("sub_wrap",   32'd0,         32'd1,         3'b000, 7'h20, 32'hFFFF_FFFF);
    run_vec("add_wrap",   32'hFFFF_FFFF, 32'd1,         3'b000, 7'h00, 32'h0000_0000);
    run_vec("add_f7_40",  32'd10,        32'd3,         3'b000, 7'h40, 32'd13);
    run_vec("sub_f7_7f",  32'd10,        32'd3,         3'b000, 7'h7F, 32'd7);
    run_vec("xor1",       32'hF0F0_F0F0, 32'hFF0F_0F0F, 3'b100, 7'h00, 32'h0FFF_FFFF);
    run_vec("xor2",       32'hF0F0_F0F0, 32'h0F0F_0F0F, 3'b100, 7'h00, 32'hFFFF_FFFF);
    run_vec("or",         32'hF0F0_F0F0, 32'h0F0F_0F0F, 3'b110, 7'h00, 32'hFFFF_FFFF);
    run_vec("and",        32'hF0F0_F0F0, 32'h0F0F_0F0F, 3'b111, 7'h00, 32'h0000_0000);
    run_vec("and_f7alt",  32'hFF00_FF00, 32'h0FF0_0FF0, 3'b111, 7'h20, 32'h0F00_0F00);
    run_vec("sll",        32'd1,         32'd4,         3'b001, 7'h00, 32'd16);
    run_vec("sll_b24",    32'd1,         32'h24,        3'b001, 7'h00, 32'd16);
    run_vec("sll_31",     32'd1,         32'd31,        3'b001, 7'h00, 32'h8000_0000);
    run_vec("sll_f7alt",  32'd3,         32'd1,         3'b001, 7'h20, 32'd6);
    run_vec("srl",        32'd16,        32'd4,         3'b101, 7'h00, 32'd1);
    run_vec("srl_neg",    32'hFFFF_FFF0, 32'd4,         3'b101, 7'h00, 32'h0FFF_FFFF);
    run_vec("sra",        32'hFFFF_FFF0, 32'd4,         3'b101, 7'h20, 32'hFFFF_FFFF);
    run_vec("sra_amt0",   32'h8000_0000, 32'd0,         3'b101, 7'h20, 32'h8000_0000);
    run_vec("sra_31",     32'h8000_0000, 32'd31,        3'b101, 7'h20, 32'hFFFF_FFFF);
    run_vec("sra_pos",    32'h4000_0000, 32'h3E,        3'b101, 7'h20, 32'h0000_0001);
    run_vec("slt",        32'd5,         32'd10,        3'b010, 7'h00, 32'd1);
    run_vec("slt_neg",    32'hFFFF_FFFF, 32'd10,        3'b010, 7'h00, 32'd1);
    run_vec("slt_eq",     32'd7,         32'd7,         3'b010, 7'h00, 32'd0);
    run_vec("sltu_big",   32'hFFFF_FFFF, 32'd10,        3'b011, 7'h00, 32'd0);
    run_vec("sltu_f7alt", 32'd3,         32'd10,        3'b011, 7'h20, 32'd1);

    // Reset asserted across clock edges must leave the combinational result untouched.
    run_vec("pre_rst_sub", 32'd5, 32'd3, 3'b000, 7'h20, 32'd2);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_held", Result, 32'd2);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_released", Result, 32'd2);

    // Clockless: stop the clock and drive it to X.
    clk_run = 1'b0;
    #6;
    clk = 1'bx;
    run_vec("nclk_add",  32'd5,         32'd3,  3'b000, 7'h00, 32'd8);
    run_vec("nclk_sra",  32'hFFFF_FFF0, 32'd4,  3'b101, 7'h20, 32'hFFFF_FFFF);
    run_vec("nclk_sltu", 32'd2,         32'd10, 3'b011, 7'h00, 32'd1);
    run_vec("nclk_xor",  32'h1234_5678, 32'hFFFF_0000, 3'b100, 7'h00, 32'hEDCB_5678);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
